// File: rtl/flit_injector.sv
// Packet source for one node's local router port: turns a command plus a payload
// stream into head/body/tail flits (or a lone HEADER), gated by per-VC credits.
module flit_injector #(
   parameter int NUM_OF_NODES            = 8,
   parameter int FLIT_DATA_WIDTH         = 16,
   parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
   parameter int NODE_ID                 = 0,
   parameter int CREDITS_PER_VC          = 2,
   parameter int MAX_DATA_FLITS          = 4,
   parameter int DEST_NODE_WIDTH         = $clog2(NUM_OF_NODES),
   parameter int VC_W                    = $clog2(NUM_OF_VIRTUAL_CHANNELS),
   parameter int LEN_W                   = $clog2(MAX_DATA_FLITS + 1),
   parameter int FLIT_TOTAL_WIDTH        = 2 + VC_W + FLIT_DATA_WIDTH
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               pkt_valid,
   output logic                               pkt_ready,
   input  logic [DEST_NODE_WIDTH-1:0]         pkt_dest,
   input  logic [VC_W-1:0]                    pkt_vc,
   input  logic [LEN_W-1:0]                   pkt_len,
   input  logic                               body_valid,
   output logic                               body_ready,
   input  logic [FLIT_DATA_WIDTH-1:0]         body_data,
   input  logic [NUM_OF_VIRTUAL_CHANNELS-1:0] credit_in,
   output logic                               flit_valid,
   output logic [FLIT_TOTAL_WIDTH-1:0]        flit_out,
   output logic                               busy,
   output logic [15:0]                        pkts_sent
);
   localparam int CRED_W = $clog2(CREDITS_PER_VC + 1);
   localparam int FILL_W = FLIT_DATA_WIDTH - 2 * DEST_NODE_WIDTH;
   localparam logic [CRED_W-1:0]          CRED_FULL = CRED_W'(CREDITS_PER_VC);
   localparam logic [LEN_W-1:0]           MAX_LEN   = LEN_W'(MAX_DATA_FLITS);
   localparam logic [DEST_NODE_WIDTH-1:0] SRC_ID    = DEST_NODE_WIDTH'(NODE_ID);
   localparam logic [1:0] TYPE_HEAD   = 2'b01;
   localparam logic [1:0] TYPE_HEADER = 2'b11;
   localparam logic [1:0] TYPE_BODY   = 2'b10;
   localparam logic [1:0] TYPE_TAIL   = 2'b00;

   typedef enum logic [1:0] {IDLE = 2'd0, SEND_HEAD = 2'd1, SEND_DATA = 2'd2} state_t;

   state_t                                state_reg;
   logic [DEST_NODE_WIDTH-1:0]            dest_reg;
   logic [VC_W-1:0]                       vc_reg;
   logic [LEN_W-1:0]                      remaining_reg;
   logic                                  pkt_ready_reg;
   logic                                  flit_valid_reg;
   logic [FLIT_TOTAL_WIDTH-1:0]           flit_out_reg;
   logic [FLIT_TOTAL_WIDTH-1:0]           flit_next;
   logic [15:0]                           pkts_sent_reg;
   logic [NUM_OF_VIRTUAL_CHANNELS-1:0]    has_credit;
   logic                                  credit_ok;
   logic                                  send_head;
   logic                                  send_data;
   logic                                  send;
   logic [LEN_W-1:0]                      len_clamped;
   logic [FLIT_DATA_WIDTH-1:0]            head_payload;

   // Send decisions look only at the registered counters, so a returned credit
   // becomes usable the cycle after it arrives.
   assign credit_ok    = has_credit[vc_reg];
   assign send_head    = (state_reg == SEND_HEAD) && credit_ok;
   assign send_data    = (state_reg == SEND_DATA) && credit_ok && body_valid;
   assign send         = send_head || send_data;
   assign len_clamped  = (pkt_len > MAX_LEN) ? MAX_LEN : pkt_len;
   assign head_payload = {dest_reg, SRC_ID, {FILL_W{1'b0}}};

   always_comb begin
      flit_next = '0;
      if (state_reg == SEND_HEAD)
         flit_next = {(remaining_reg == '0) ? TYPE_HEADER : TYPE_HEAD, vc_reg, head_payload};
      else
         flit_next = {(remaining_reg == LEN_W'(1)) ? TYPE_TAIL : TYPE_BODY, vc_reg, body_data};
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_OF_VIRTUAL_CHANNELS; gi++) begin : g_credit
         logic              dec_credit;
         logic [CRED_W-1:0] cnt_reg;

         assign dec_credit     = send && (vc_reg == VC_W'(gi));
         assign has_credit[gi] = (cnt_reg != '0);

         // A return at full count is dropped; send and return together cancel out.
         always_ff @(posedge clk) begin
            if (reset)
               cnt_reg <= CRED_FULL;
            else if (credit_in[gi] && !dec_credit) begin
               if (cnt_reg != CRED_FULL)
                  cnt_reg <= cnt_reg + CRED_W'(1);
            end else if (dec_credit && !credit_in[gi])
               cnt_reg <= cnt_reg - CRED_W'(1);
         end

         assert property (@(posedge clk) disable iff (reset) cnt_reg <= CRED_FULL);
         assert property (@(posedge clk) disable iff (reset) !(dec_credit && cnt_reg == '0));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         dest_reg       <= '0;
         vc_reg         <= '0;
         remaining_reg  <= '0;
         pkt_ready_reg  <= 1'b0;
         flit_valid_reg <= 1'b0;
         flit_out_reg   <= '0;
         pkts_sent_reg  <= '0;
      end else begin
         flit_valid_reg <= send;
         flit_out_reg   <= send ? flit_next : '0;
         case (state_reg)
            IDLE: begin
               if (pkt_valid && pkt_ready_reg) begin
                  dest_reg      <= pkt_dest;
                  vc_reg        <= pkt_vc;
                  remaining_reg <= len_clamped;
                  pkt_ready_reg <= 1'b0;
                  state_reg     <= SEND_HEAD;
               end else begin
                  pkt_ready_reg <= 1'b1;
               end
            end
            SEND_HEAD: begin
               if (credit_ok) begin
                  if (remaining_reg == '0) begin
                     state_reg     <= IDLE;
                     pkt_ready_reg <= 1'b1;
                     pkts_sent_reg <= pkts_sent_reg + 16'd1;
                  end else begin
                     state_reg <= SEND_DATA;
                  end
               end
            end
            SEND_DATA: begin
               if (send_data) begin
                  remaining_reg <= remaining_reg - LEN_W'(1);
                  if (remaining_reg == LEN_W'(1)) begin
                     state_reg     <= IDLE;
                     pkt_ready_reg <= 1'b1;
                     pkts_sent_reg <= pkts_sent_reg + 16'd1;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign pkt_ready  = pkt_ready_reg;
   assign body_ready = send_data && !reset;
   assign flit_valid = flit_valid_reg;
   assign flit_out   = flit_out_reg;
   assign busy       = (state_reg != IDLE);
   assign pkts_sent  = pkts_sent_reg;
endmodule
